// File: rtl/write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : write_sequencer
// Description : Buffers hysteresis edge pixels in a small FIFO and streams
//               them to an SRAM write port in raster order, then requests a
//               dump of the frame. Optional macro BORDER_CLEAR_EN forces
//               border pixels to 8'h00.
// Revision    : 1.0 - initial release
// ============================================================================
module write_sequencer #(
  parameter int WIDTH  = 512,
  parameter int HEIGHT = 512,
  parameter int ADDR_W = 18,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pix_valid,
  input  logic              pix_data,
  output logic              pix_ready,
  input  logic              sram_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] address,
  output logic [7:0]        output_data,
  output logic              file_dump,
  output logic              busy,
  output logic              frame_done
);

  localparam int c_total = WIDTH * HEIGHT;
  localparam int c_xw    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int c_yw    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int c_cw    = $clog2(c_total + 1);
  localparam int c_pw    = $clog2(DEPTH);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_dump = 2'd2;

  localparam logic [ADDR_W-1:0] c_width_a = ADDR_W'(WIDTH);

  logic [1:0]        r_state;
  logic [DEPTH-1:0]  r_fifo;
  logic [c_pw-1:0]   r_wr_ptr;
  logic [c_pw-1:0]   r_rd_ptr;
  logic [c_pw:0]     r_count;
  logic [c_xw-1:0]   r_x;
  logic [c_yw-1:0]   r_y;
  logic [c_cw-1:0]   r_acc;
  logic              r_we;
  logic              r_last;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_frame_done;

  logic              w_full;
  logic              w_push;
  logic              w_pop;
  logic              w_x_last;
  logic              w_y_last;
  logic              w_border;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_data;

  assign w_full    = (r_count == (c_pw+1)'(DEPTH));
  assign pix_ready = (r_state == c_run) && !w_full && (r_acc < c_cw'(c_total));
  assign w_push    = pix_valid && pix_ready;
  // Occupancy is the registered count, so a pixel pushed into an empty FIFO waits a cycle.
  assign w_pop     = (r_state == c_run) && (r_count != '0) && sram_ready;

  assign w_x_last  = (r_x == c_xw'(WIDTH - 1));
  assign w_y_last  = (r_y == c_yw'(HEIGHT - 1));
  assign w_addr    = ADDR_W'(r_x) + ADDR_W'(r_y) * c_width_a;

`ifdef BORDER_CLEAR_EN
  assign w_border  = (r_x == '0) || w_x_last || (r_y == '0) || w_y_last;
`else
  assign w_border  = 1'b0;
`endif
  assign w_data    = (r_fifo[r_rd_ptr] && !w_border) ? 8'hFF : 8'h00;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_idle;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_acc        <= '0;
      r_we         <= 1'b0;
      r_last       <= 1'b0;
      r_addr       <= '0;
      r_data       <= 8'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_we         <= w_pop;
      r_frame_done <= (r_state == c_dump);

      if (w_pop) begin
        r_addr   <= w_addr;
        r_data   <= w_data;
        r_last   <= w_x_last && w_y_last;
        r_rd_ptr <= r_rd_ptr + c_pw'(1);
        if (w_x_last) begin
          r_x <= '0;
          if (!w_y_last) begin
            r_y <= r_y + c_yw'(1);
          end
        end else begin
          r_x <= r_x + c_xw'(1);
        end
      end

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_pw'(1);
        r_acc    <= r_acc + c_cw'(1);
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_pw+1)'(1);
        2'b01:   r_count <= r_count - (c_pw+1)'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        c_idle: begin
          if (start) begin
            r_state  <= c_run;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
          end
        end
        c_run: begin
          if (r_we && r_last) begin
            r_state <= c_dump;
          end
        end
        c_dump:  r_state <= c_idle;
        default: r_state <= c_idle;
      endcase
    end
  end

  assign write_enable = r_we;
  assign address      = r_addr;
  assign output_data  = r_data;
  assign file_dump    = (r_state == c_dump);
  assign busy         = (r_state != c_idle);
  assign frame_done   = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_write_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_sequencer
// Description : Directed self-checking bench for write_sequencer (4x4 frame).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_sequencer;

  localparam int W     = 4;
  localparam int H     = 4;
  localparam int D     = 4;
  localparam int AW    = 8;
  localparam int TOTAL = W * H;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pix_valid;
  logic          pix_data;
  logic          pix_ready;
  logic          sram_ready;
  logic          write_enable;
  logic [AW-1:0] address;
  logic [7:0]    output_data;
  logic          file_dump;
  logic          busy;
  logic          frame_done;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;
  int g_wcount = 0;

  always #5 clk = ~clk;

  write_sequencer #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_ready(pix_ready), .sram_ready(sram_ready),
    .write_enable(write_enable), .address(address), .output_data(output_data),
    .file_dump(file_dump), .busy(busy), .frame_done(frame_done)
  );

  // Frame model: 0 idle, 1 streaming, 2 dump; pixels held in a plain queue
  int            m_state = 0;
  bit            q[$];
  int            m_acc = 0;
  int            m_wr = 0;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [7:0]    m_data = 8'h00;
  logic          m_done = 1'b0;

  function automatic logic [7:0] exp_data(input int idx, input bit b);
    logic [7:0] d;
    d = b ? 8'hFF : 8'h00;
`ifdef BORDER_CLEAR_EN
    if ((idx % W) == 0 || (idx % W) == W - 1 || (idx / W) == 0 || (idx / W) == H - 1) d = 8'h00;
`endif
    return d;
  endfunction

  always @(posedge clk) begin : model
    bit rdy, push, pop, b, to_dump;
    if (rst) begin
      m_state = 0; q.delete(); m_acc = 0; m_wr = 0;
      m_we = 1'b0; m_addr = '0; m_data = 8'h00; m_done = 1'b0;
    end else begin
      rdy     = (m_state == 1) && (q.size() < D) && (m_acc < TOTAL);
      push    = pix_valid && rdy;
      pop     = (m_state == 1) && (q.size() > 0) && sram_ready;
      to_dump = (m_state == 1) && m_we && (m_wr == TOTAL);
      m_done  = (m_state == 2);
      m_we    = pop;
      if (pop) begin
        b = q.pop_front();
        m_addr = AW'(m_wr);
        m_data = exp_data(m_wr, b);
        m_wr++;
      end
      if (push) begin
        q.push_back(pix_data);
        m_acc++;
      end
      case (m_state)
        0: if (start) begin m_state = 1; q.delete(); m_acc = 0; m_wr = 0; end
        1: if (to_dump) m_state = 2;
        default: m_state = 0;
      endcase
    end
  end

  // Write / pulse log used by the literal end-of-frame expectations
  logic [AW-1:0] wr_a[$];
  logic [7:0]    wr_d[$];
  int            dump_cnt = 0;
  int            done_cnt = 0;

  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      wr_a.push_back(address);
      wr_d.push_back(output_data);
    end
    if (file_dump === 1'b1) dump_cnt++;
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit er;
    er = (m_state == 1) && (q.size() < D) && (m_acc < TOTAL);
    check("pix_ready", 32'(pix_ready), 32'(er));
    check("busy", 32'(busy), 32'(m_state != 0));
    check("file_dump", 32'(file_dump), 32'(m_state == 2));
    check("frame_done", 32'(frame_done), 32'(m_done));
    check("write_enable", 32'(write_enable), 32'(m_we));
    check("address", 32'(address), 32'(m_addr));
    check("output_data", 32'(output_data), 32'(m_data));
  endtask

  // One clock: drive inputs, compare at negedge, optionally assert rst after N writes
  task automatic cyc(input bit v, input bit d, input bit sr, input bit st,
                     input int rst_at, output bit acc);
    pix_valid = v; pix_data = d; sram_ready = sr; start = st;
    @(negedge clk);
    if (check_en) compare_all();
    if (write_enable === 1'b1) g_wcount++;
    if (rst_at > 0 && g_wcount == rst_at && !rst) rst = 1'b1;
    acc = v && (pix_ready === 1'b1) && !rst;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit a;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, a);
    cyc(0, 0, 0, 0, 0, a);
    rst = 1'b0;
    check_en = 1'b1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, a);
  endtask

  // pmode 0: all ones, 1: alternating 1,0; smode 0: sram always ready, 1: toggling
  task automatic frame(input int n_offer, input int pmode, input int smode,
                       input int start_at, input int budget, output int accepted);
    bit acc, d, sr;
    int base;
    base = done_cnt;
    accepted = 0;
    cyc(0, 0, 0, 1, 0, acc);
    for (int c = 0; c < budget && done_cnt == base; c++) begin
      d  = (pmode == 1) ? ((accepted % 2) == 0) : 1'b1;
      sr = (smode == 0) ? 1'b1 : ((c % 2) == 1);
      cyc(accepted < n_offer, d, sr, c == start_at, 0, acc);
      if (acc) accepted++;
    end
    if (done_cnt == base) begin
      n_vec++; n_err++;
      $display("FAIL frame_timeout: got no frame_done, expected one within %0d cycles", budget);
    end
  endtask

  initial begin : stim
    int acc_n, wb, db, fb;
    bit a;
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 1'b0; sram_ready = 1'b0;

    // Reset state
    do_reset();
    check("rst_we", 32'(write_enable), 32'h0);
    check("rst_addr", 32'(address), 32'h0);
    check("rst_data", 32'(output_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_ready", 32'(pix_ready), 32'h0);
    check("rst_dump", 32'(file_dump), 32'h0);
    check("rst_done", 32'(frame_done), 32'h0);

    // Full frame of ones, SRAM always ready
    wb = wr_a.size(); db = dump_cnt; fb = done_cnt;
    frame(16, 0, 0, -1, 100, acc_n);
    idle(3);
    check("t1_accepted", 32'(acc_n), 32'd16);
    check("t1_writes", 32'(wr_a.size() - wb), 32'd16);
    for (int i = 0; i < 16 && wb + i < wr_a.size(); i++) begin
      check("t1_addr", 32'(wr_a[wb+i]), 32'(i));
`ifdef BORDER_CLEAR_EN
      check("t1_data", 32'(wr_d[wb+i]), (i == 5 || i == 6 || i == 9 || i == 10) ? 32'hFF : 32'h00);
`else
      check("t1_data", 32'(wr_d[wb+i]), 32'hFF);
`endif
    end
    check("t1_dumps", 32'(dump_cnt - db), 32'd1);
    check("t1_dones", 32'(done_cnt - fb), 32'd1);

    // SRAM stalled: FIFO fills at 4, then drains in order
    do_reset();
    wb = wr_a.size();
    acc_n = 0;
    cyc(0, 0, 0, 1, 0, a);
    for (int i = 0; i < 8; i++) begin
      cyc(acc_n < 5, 1, 0, 0, 0, a);
      if (a) acc_n++;
    end
    check("t2_accepted", 32'(acc_n), 32'd4);
    check("t2_ready_full", 32'(pix_ready), 32'h0);
    idle(0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 0, a);
    check("t2_writes", 32'(wr_a.size() - wb), 32'd4);
    for (int i = 0; i < 4 && wb + i < wr_a.size(); i++)
      check("t2_addr", 32'(wr_a[wb+i]), 32'(i));

    // Alternating pixels with toggling sram_ready
    do_reset();
    wb = wr_a.size(); db = dump_cnt; fb = done_cnt;
    frame(16, 1, 1, -1, 200, acc_n);
    idle(3);
    check("t3_writes", 32'(wr_a.size() - wb), 32'd16);
    for (int i = 0; i < 16 && wb + i < wr_a.size(); i++) begin
      check("t3_addr", 32'(wr_a[wb+i]), 32'(i));
`ifdef BORDER_CLEAR_EN
      check("t3_data", 32'(wr_d[wb+i]), (i == 6 || i == 10) ? 32'hFF : 32'h00);
`else
      check("t3_data", 32'(wr_d[wb+i]), ((i % 2) == 0) ? 32'hFF : 32'h00);
`endif
    end
    check("t3_dumps", 32'(dump_cnt - db), 32'd1);
    check("t3_dones", 32'(done_cnt - fb), 32'd1);

    // Reset after 6 writes aborts the frame; restart begins at address 0
    do_reset();
    wb = wr_a.size(); db = dump_cnt;
    g_wcount = 0;
    cyc(0, 0, 0, 1, 0, a);
    for (int i = 0; i < 60 && !rst; i++) cyc(1, 1, 1, 0, 6, a);
    cyc(0, 0, 0, 0, 0, a);
    rst = 1'b0;
    idle(8);
    check("t4_writes", 32'(wr_a.size() - wb), 32'd6);
    check("t4_dumps", 32'(dump_cnt - db), 32'd0);
    wb = wr_a.size();
    frame(16, 0, 0, -1, 100, acc_n);
    idle(2);
    check("t4_restart_writes", 32'(wr_a.size() - wb), 32'd16);
    if (wr_a.size() > wb) check("t4_restart_addr0", 32'(wr_a[wb]), 32'h0);

    // Overflow offer and start pulse while running
    do_reset();
    wb = wr_a.size(); db = dump_cnt; fb = done_cnt;
    frame(20, 0, 0, 5, 100, acc_n);
    idle(3);
    check("t5_accepted", 32'(acc_n), 32'd16);
    check("t5_writes", 32'(wr_a.size() - wb), 32'd16);
    check("t5_dumps", 32'(dump_cnt - db), 32'd1);
    check("t5_dones", 32'(done_cnt - fb), 32'd1);
    check("t5_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/write_sequencer.md
WRITE_SEQUENCER -- requirements
Module: write_sequencer

Interface
REQ-001 Parameter WIDTH, default 512, image width in pixels; SHALL be a power of two.
REQ-002 Parameter HEIGHT, default 512, image height in pixels.
REQ-003 Parameter ADDR_W, default 18, SRAM address width; SHALL satisfy 2^ADDR_W >= WIDTH*HEIGHT.
REQ-004 Parameter DEPTH, default 4, pixel FIFO depth; SHALL be a power of two, >= 2.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  begin one frame; sampled only in IDLE.
REQ-008 pix_valid  input  1  hysteresis stage offers a pixel.
REQ-009 pix_data  input  1  hysteresis result; 1 = edge, 0 = no edge.
REQ-010 pix_ready  output  1  block accepts a pixel this cycle.
REQ-011 sram_ready  input  1  SRAM write port can take a write this cycle.
REQ-012 write_enable  output  1  registered one-cycle SRAM write strobe.
REQ-013 address  output  ADDR_W  registered SRAM write address.
REQ-014 output_data  output  8  registered SRAM write data.
REQ-015 file_dump  output  1  one-cycle SRAM dump request after the last write.
REQ-016 busy  output  1  high whenever the state is not IDLE.
REQ-017 frame_done  output  1  one-cycle pulse on return to IDLE after a dump.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DUMP; IDLE->RUN on start; RUN->DUMP on the cycle the final write_enable is high; DUMP->IDLE after one cycle; start outside IDLE SHALL be ignored.
REQ-019 Entering RUN SHALL clear the FIFO, x/y write counters and the accept counter.
REQ-020 A pixel is accepted when pix_valid && pix_ready; pix_ready SHALL be 1 only in RUN with FIFO not full and accept counter < WIDTH*HEIGHT.
REQ-021 A pop SHALL occur in RUN when FIFO non-empty and sram_ready; next cycle write_enable=1, output_data=8'hFF if popped bit is 1 else 8'h00, address = x + WIDTH*y, zero-extended to ADDR_W.
REQ-022 write_enable SHALL be 0 in every cycle not following a pop; address and output_data SHALL hold their last values.
REQ-023 Per pop, x SHALL increment; at x = WIDTH-1 it SHALL wrap to 0 and y SHALL increment; no wrap beyond y = HEIGHT-1.
REQ-024 Simultaneous push and pop SHALL be permitted when non-empty, leaving occupancy unchanged; a push into an empty FIFO SHALL NOT pop in the same cycle.
REQ-025 Minimum latency from acceptance edge to write_enable high SHALL be 2 cycles.
REQ-026 file_dump SHALL be high for exactly the DUMP cycle; frame_done SHALL be high for exactly the following cycle (first IDLE cycle).
REQ-027 Pixels offered after WIDTH*HEIGHT accepts SHALL be refused (pix_ready=0) and never written.

Reset
REQ-028 On rst: state IDLE, FIFO empty, counters 0, pix_ready=0, write_enable=0, address=0, output_data=8'h00, file_dump=0, busy=0, frame_done=0.
REQ-029 rst mid-frame SHALL abort the frame with no further writes and no file_dump.
REQ-030 rst SHALL take priority over start and all other inputs.

Configuration
REQ-031 With BORDER_CLEAR_EN defined, writes where x=0, x=WIDTH-1, y=0 or y=HEIGHT-1 SHALL use output_data=8'h00 regardless of pixel value; address, timing and counting are unchanged.
REQ-032 Without BORDER_CLEAR_EN, output_data SHALL follow REQ-021 for every pixel.

Verification (WIDTH=4, HEIGHT=4, DEPTH=4 unless stated)
REQ-033 rst held 2 cycles, then start, 16 pixels all 1, sram_ready=1 -> 16 write_enable pulses at addresses 0..15 with data 8'hFF, one file_dump, then one frame_done.
REQ-034 sram_ready=0 while 5 pixels offered -> exactly 4 accepted, pix_ready=0 afterward; sram_ready=1 -> writes at addresses 0..3 in order.
REQ-035 Pixels alternating 1,0 with sram_ready toggling every cycle -> address sequence 0..15 gap-free, data alternating FF,00.
REQ-036 rst asserted after 6 writes -> no further write_enable, no file_dump; new start restarts at address 0.
REQ-037 20 pixels offered -> exactly 16 accepted; start pulsed during RUN -> ignored.
REQ-038 BORDER_CLEAR_EN defined, all pixels 1 -> data 8'hFF only at addresses 5, 6, 9, 10; all others 8'h00.
